// File: rtl/neurotransmitter_accumulator.sv
// Saturating level integrator for one neurotransmitter, driven by a regulator's
// inc/dec/fast command triple. The level moves by one LSB per prescaler tick
// (slow or fast rate) and is published in full and as a 2-bit band with hysteresis.
// Optional build macro: NT_DECAY_EN -- idle/conflicting ticks pull the level
// one step back toward INIT (homeostatic reuptake).
module neurotransmitter_accumulator #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned SLOW_DIV = 16,
    parameter int unsigned FAST_DIV = 4,
    parameter int unsigned INIT     = 128,
    parameter int unsigned HYST     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             inc,
    input  logic             dec,
    input  logic             fast,
    output logic [WIDTH-1:0] level,
    output logic [1:0]       level_q,
    output logic             at_min,
    output logic             at_max
);

    localparam int unsigned      CNT_W    = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;
    localparam logic [WIDTH-1:0] LVL_INIT = WIDTH'(INIT);
    localparam logic [WIDTH-1:0] LVL_MAX  = {WIDTH{1'b1}};
    localparam int unsigned      BAND     = 32'd1 << (WIDTH - 2);

    // Band thresholds: UPn enters band n from below, DNn leaves band n downward.
    localparam int unsigned UP1 = BAND + HYST;
    localparam int unsigned UP2 = 2 * BAND + HYST;
    localparam int unsigned UP3 = 3 * BAND + HYST;
    localparam int unsigned DN1 = BAND - HYST;
    localparam int unsigned DN2 = 2 * BAND - HYST;
    localparam int unsigned DN3 = 3 * BAND - HYST;

    typedef enum logic [1:0] {
        StQ0 = 2'b00,
        StQ1 = 2'b01,
        StQ2 = 2'b10,
        StQ3 = 2'b11
    } q_state_e;

    // Reset band is the raw top two bits of INIT, no hysteresis applied.
    localparam logic [1:0] INIT_BAND = LVL_INIT[WIDTH-1:WIDTH-2];
    localparam q_state_e   ST_INIT   = q_state_e'(INIT_BAND);

    logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
    logic [WIDTH-1:0] lvl_q, lvl_d;
    q_state_e         state_q, state_d;
    int unsigned      lim;
    int unsigned      lvl_int;
    logic             tick;

    // Prescaler: limit follows this cycle's fast so a raised fast ticks at once.
    always_comb begin
        lim       = fast ? FAST_DIV : SLOW_DIV;
        tick      = ena && (32'(div_cnt_q) >= (lim - 32'd1));
        div_cnt_d = div_cnt_q;
        if (ena) begin
            div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
        end
    end

    // Level next-state: single-LSB saturating step, commands sampled on ticks only.
    always_comb begin
        lvl_d = lvl_q;
        if (tick) begin
            if (inc && !dec) begin
                if (lvl_q != LVL_MAX) lvl_d = lvl_q + 1'b1;
            end else if (dec && !inc) begin
                if (lvl_q != '0) lvl_d = lvl_q - 1'b1;
            end
`ifdef NT_DECAY_EN
            else if (lvl_q < LVL_INIT) begin
                lvl_d = lvl_q + 1'b1;
            end else if (lvl_q > LVL_INIT) begin
                lvl_d = lvl_q - 1'b1;
            end
`endif
        end
    end

    // Quantizer next-state: at most one band step per enabled cycle.
    always_comb begin
        state_d = state_q;
        lvl_int = 32'(lvl_q);
        if (ena) begin
            case (state_q)
                StQ0: begin
                    if (lvl_int >= UP1) state_d = StQ1;
                end
                StQ1: begin
                    if (lvl_int >= UP2)      state_d = StQ2;
                    else if (lvl_int < DN1)  state_d = StQ0;
                end
                StQ2: begin
                    if (lvl_int >= UP3)      state_d = StQ3;
                    else if (lvl_int < DN2)  state_d = StQ1;
                end
                StQ3: begin
                    if (lvl_int < DN3) state_d = StQ2;
                end
                default: state_d = state_q;
            endcase
        end
    end

    // Prescaler and level registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
            lvl_q     <= LVL_INIT;
        end else begin
            div_cnt_q <= div_cnt_d;
            lvl_q     <= lvl_d;
        end
    end

    // Quantizer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Outputs: flags decode the registered level directly.
    always_comb begin
        level   = lvl_q;
        level_q = state_q;
        at_min  = (lvl_q == '0);
        at_max  = (lvl_q == LVL_MAX);
    end

endmodule

// File: tb/tb_neurotransmitter_accumulator.sv
// Scoreboard bench for neurotransmitter_accumulator with default parameters.
// The driver computes the expected post-edge state from the behavioural rules
// and queues it; a monitor pops and compares after every rising edge.
module tb_neurotransmitter_accumulator;

    localparam int B     = 64;
    localparam int H     = 4;
    localparam int INITV = 128;
    localparam int MAXL  = 255;
    localparam int SLOW  = 16;
    localparam int FAST  = 4;

    logic       clk = 1'b0;
    logic       rst_n, ena, inc, dec, fast;
    logic [7:0] level;
    logic [1:0] level_q;
    logic       at_min, at_max;

    neurotransmitter_accumulator dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .inc     (inc),
        .dec     (dec),
        .fast    (fast),
        .level   (level),
        .level_q (level_q),
        .at_min  (at_min),
        .at_max  (at_max)
    );

    always #5 clk = ~clk;

    typedef struct {
        int lvl;
        int q;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state: level, band, enabled cycles since the last tick.
    int m_lvl, m_q, m_cnt;

    task automatic check(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    function automatic void model_reset();
        m_lvl = INITV;
        m_q   = INITV / B;
        m_cnt = 0;
    endfunction

    task automatic model_cycle(input bit r, input bit e, input bit i, input bit d,
                               input bit f);
        int lim;
        int nq;
        exp_t x;
        if (!r) begin
            model_reset();
        end else if (e) begin
            lim = f ? FAST : SLOW;
            nq  = m_q;
            if (m_q < 3 && m_lvl >= (m_q + 1) * B + H) nq = m_q + 1;
            else if (m_q > 0 && m_lvl < m_q * B - H)   nq = m_q - 1;
            if (m_cnt >= lim - 1) begin
                if (i && !d)      m_lvl = (m_lvl < MAXL) ? m_lvl + 1 : MAXL;
                else if (d && !i) m_lvl = (m_lvl > 0) ? m_lvl - 1 : 0;
`ifdef NT_DECAY_EN
                else if (m_lvl < INITV) m_lvl = m_lvl + 1;
                else if (m_lvl > INITV) m_lvl = m_lvl - 1;
`endif
                m_cnt = 0;
            end else begin
                m_cnt = m_cnt + 1;
            end
            m_q = nq;
        end
        x.lvl = m_lvl;
        x.q   = m_q;
        exp_q.push_back(x);
    endtask

    task automatic step(input bit r, input bit e, input bit i, input bit d, input bit f);
        @(negedge clk);
        rst_n = r;
        ena   = e;
        inc   = i;
        dec   = d;
        fast  = f;
        model_cycle(r, e, i, d, f);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every rising edge the DUT presents a new state to compare.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                check("level", int'(level), x.lvl);
                check("level_q", int'(level_q), x.q);
                check("at_min", int'(at_min), int'(x.lvl == 0));
                check("at_max", int'(at_max), int'(x.lvl == MAXL));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, got t=%0t expected < 1000000", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int guard;
        int hold_lvl;
        rst_n = 1'b0;
        ena   = 1'b0;
        inc   = 1'b0;
        dec   = 1'b0;
        fast  = 1'b0;
        model_reset();
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        after_edge();
        check("reset_level", int'(level), 128);
        check("reset_level_q", int'(level_q), 2);

        // Slow integrate: first change on the 16th edge, 10 ticks in 160 cycles.
        for (int k = 1; k <= 160; k++) begin
            step(1, 1, 1, 0, 0);
            if (k == 15) begin
                after_edge();
                check("slow_before_first_tick", int'(level), 128);
            end
            if (k == 16) begin
                after_edge();
                check("slow_first_tick", int'(level), 129);
            end
        end
        after_edge();
        check("slow_integrate", int'(level), 138);
        check("slow_level_q", int'(level_q), 2);

        // Fast switch at div_cnt=10: immediate tick, then every 4 cycles.
        repeat (10) step(1, 1, 1, 0, 0);
        after_edge();
        check("fast_switch_pre", int'(level), 138);
        step(1, 1, 1, 0, 1);
        after_edge();
        check("fast_switch_immediate", int'(level), 139);
        repeat (39) step(1, 1, 1, 0, 1);
        after_edge();
        check("fast_switch_40", int'(level), 148);

        // Climb to 200 and assert reset mid-count.
        guard = 0;
        while (m_lvl < 200 && guard < 1000) begin
            step(1, 1, 1, 0, 1);
            guard++;
        end
        after_edge();
        check("climb_to_200", int'(level), 200);
        @(negedge clk);
        rst_n = 1'b0;
        model_cycle(0, 1, 1, 0, 1);
        #1;
        check("async_reset_level", int'(level), 128);
        check("async_reset_level_q", int'(level_q), 2);
        check("async_reset_at_min", int'(at_min), 0);
        check("async_reset_at_max", int'(at_max), 0);

        // Decrement to the floor and hold there.
        repeat (600) step(1, 1, 0, 1, 1);
        after_edge();
        check("floor_level", int'(level), 0);
        check("floor_at_min", int'(at_min), 1);
        check("floor_level_q", int'(level_q), 0);

        // Hysteresis on the way up: band 1 entered one cycle after level 68.
        guard = 0;
        while (m_lvl < 68 && guard < 1000) begin
            step(1, 1, 1, 0, 1);
            guard++;
        end
        after_edge();
        check("hyst_level_68", int'(level), 68);
        check("hyst_still_q0", int'(level_q), 0);
        step(1, 1, 0, 0, 1);
        after_edge();
        check("hyst_enter_q1", int'(level_q), 1);

        // Conflicting requests hold (or decay toward INIT when enabled).
        hold_lvl = m_lvl;
        repeat (64) step(1, 1, 1, 1, 0);
        after_edge();
`ifdef NT_DECAY_EN
        check("conflict_decay", int'(level), hold_lvl + 4);
`else
        check("conflict_hold", int'(level), hold_lvl);
`endif

        // Disabled: everything frozen despite inc.
        hold_lvl = m_lvl;
        repeat (50) step(1, 0, 1, 0, 1);
        after_edge();
        check("ena_low_freeze", int'(level), hold_lvl);

        // Saturate at the top.
        repeat (1100) step(1, 1, 1, 0, 1);
        after_edge();
        check("ceiling_level", int'(level), 255);
        check("ceiling_at_max", int'(at_max), 1);
        check("ceiling_level_q", int'(level_q), 3);

        // Randomized traffic, mostly enabled, occasional reset.
        for (int k = 0; k < 3000; k++) begin
            step(bit'($urandom_range(0, 499) != 0), bit'($urandom_range(0, 9) < 8),
                 bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                 bit'($urandom_range(0, 1)));
        end

        @(posedge clk);
        #2;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/neurotransmitter_accumulator.md
Name: neurotransmitter_accumulator

Overview:
- Integrating consumer of a neurotransmitter regulator's inc/dec/fast command triple.
- Holds one neurotransmitter's internal level in a saturating counter and updates it at a prescaled rate (slow or fast).
- Publishes the full level plus a 2-bit quantized level with hysteresis; the 2-bit value is the field the regulators read back in their packed 10-bit level bus.
- One instance per neurotransmitter (CORT, DOP, GABA, NE, SER).

Parameters:
- WIDTH, 8: level counter width; legal 4..12.
- SLOW_DIV, 16: enabled cycles per update tick when fast=0; legal 2..2^10.
- FAST_DIV, 4: enabled cycles per update tick when fast=1; legal 1..SLOW_DIV.
- INIT, 128: reset value of level; must be <= 2^WIDTH-1.
- HYST, 4: quantizer hysteresis in level LSBs; must be < 2^(WIDTH-3).

Ports:
- clk, input, 1: single clock.
- rst_n, input, 1: reset, asynchronous, active-low.
- ena, input, 1: global enable; low freezes all state.
- inc, input, 1: increase request from the regulator.
- dec, input, 1: decrease request from the regulator.
- fast, input, 1: selects FAST_DIV as the tick period.
- level, output, WIDTH: registered internal level.
- level_q, output, 2: registered quantized level (00 low .. 11 high).
- at_min, output, 1: combinational, level == 0.
- at_max, output, 1: combinational, level == 2^WIDTH-1.

Behaviour:
- Reset (async assert, any time, including mid-count):
  - level=INIT, div_cnt=0.
  - level_q = INIT[WIDTH-1:WIDTH-2] (raw band).
  - at_min and at_max follow level.
- Prescaler div_cnt, width clog2(SLOW_DIV):
  - Only advances when ena=1.
  - lim = fast ? FAST_DIV : SLOW_DIV, using the current cycle's fast.
  - tick = ena && (div_cnt >= lim-1).
  - On tick, div_cnt<=0; otherwise div_cnt<=div_cnt+1.
  - Raising fast while div_cnt >= FAST_DIV-1 ticks in that same cycle; never skips a tick.
- Level update, on tick only, new level visible on the clock edge that ends the tick cycle:
  - inc=1, dec=0: level+1, saturating at 2^WIDTH-1.
  - dec=1, inc=0: level-1, saturating at 0.
  - inc=dec=0, or inc=dec=1: hold (see optional feature).
  - Step size is always 1; fast affects rate only.
  - inc/dec are sampled only on tick cycles. Pulses between ticks are ignored; no latching.
- Quantizer FSM:
  - States: Q0=00, Q1=01, Q2=10, Q3=11; state drives level_q. B = 2^(WIDTH-2).
  - Up transition Qs->Qs+1 (s<3) when level >= (s+1)*B + HYST.
  - Down transition Qs->Qs-1 (s>0) when level < s*B - HYST.
  - Evaluated every ena cycle from the registered level, so level_q lags level by >=1 cycle.
  - At most one state step per cycle; a large gap is closed one step per cycle.
  - Q0 never goes down; Q3 never goes up.
- ena=0: div_cnt, level and FSM all hold; outputs stay stable.
- No X propagation: all registers are reset.

Optional Feature:
- Macro: NT_DECAY_EN.
- Defined: on a tick with inc=dec=0 or inc=dec=1, level moves one step toward INIT (+1 if below, -1 if above, hold if equal). This models homeostatic reuptake.
- Undefined: level holds on such ticks; no decay logic is synthesized.

Test Plan:
All values use default parameters.
- Reset: rst_n low mid-run with level=200 -> immediately level=128, level_q=10, at_min=0, at_max=0, div_cnt=0.
- Slow integrate: ena=1, inc=1, fast=0 for 160 cycles after reset -> exactly 10 ticks, level=138; first change on the 16th cycle edge; level_q stays 10.
- Fast switch: fast=0 until div_cnt=10, then fast=1 with inc=1 -> tick in that cycle; thereafter one +1 every 4 cycles; 40 fast cycles give 10 increments.
- Saturation / at_min: dec=1, fast=1 from 128 for 600 cycles -> level reaches 0 at tick 128 and stays 0; at_min=1.
  - level_q 10->01 one cycle after level=123.
  - level_q 01->00 one cycle after level=59.
- Hysteresis: from level=59, level_q=00, inc fast -> level_q stays 00 at levels 60..67, becomes 01 one cycle after level=68.
- Edge cases:
  - inc=dec=1 for 64 slow cycles -> level unchanged (without NT_DECAY_EN).
  - ena=0 for 50 cycles with inc=1 -> level and div_cnt frozen.
  - With NT_DECAY_EN, level=138 and inc=dec=0 for 160 slow cycles -> level=128 and holds.
